// File: rtl/pipe_sched.sv
// pipe_sched: valid/ready flow controller around a fixed-latency, non-stallable
// delay pipeline. A valid-bit shadow tracks occupied pipeline stages, a result
// FIFO catches the pipeline output, and upstream is throttled by credits so the
// FIFO can never overflow while downstream stalls.
// Optional build macro PIPE_SCHED_STATS_EN adds stat_in/stat_out/stat_stall.
module pipe_sched #(
  parameter int WIDTH = 8,
  parameter int DELAY = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       pipe_reset,
  output logic [WIDTH-1:0]           pipe_sink,
  input  logic [WIDTH-1:0]           pipe_source,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
`ifdef PIPE_SCHED_STATS_EN
  output logic [31:0]                stat_in,
  output logic [31:0]                stat_out,
  output logic [31:0]                stat_stall,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int D     = (DELAY < 1) ? 1 : DELAY;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0] credits;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [D-1:0]     vld_p;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             issue;
  logic             pop;
  logic             push;

  // Pointer advance with explicit wrap, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (credits != '0) & ~pipe_reset;
  assign issue     = in_valid & in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = vld_p[D-1];
  assign pipe_sink = in_data;
  // Empty FIFO presents zero rather than a stale entry.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Pipeline reset lingers for one clock after reset_n releases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pipe_reset <= 1'b1;
    else          pipe_reset <= 1'b0;
  end

  // Credit counter and its mirror, occupancy = DEPTH - credits, both registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits   <= CNT_W'(DEPTH);
      occupancy <= '0;
    end else begin
      case ({issue, pop})
        2'b10: begin
          credits   <= credits - 1'b1;
          occupancy <= occupancy + 1'b1;
        end
        2'b01: begin
          credits   <= credits + 1'b1;
          occupancy <= occupancy - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Valid-bit shadow of the delay pipeline; stage N holds the issue from N+1 clocks ago.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < D; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // FIFO control: pointers and fill count; push and pop together leave count alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // FIFO storage captures the pipeline output in the cycle its valid bit exits.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pipe_source;
  end

`ifdef PIPE_SCHED_STATS_EN
  // Free-running handshake and stall counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_in    <= '0;
      stat_out   <= '0;
      stat_stall <= '0;
    end else begin
      if (issue)                  stat_in    <= stat_in + 1'b1;
      if (pop)                    stat_out   <= stat_out + 1'b1;
      if (out_valid && !out_ready) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_sched.sv
// tb_pipe_sched: directed bench for pipe_sched. Instance A uses DELAY=4/DEPTH=8,
// instance B uses DELAY=1/DEPTH=3 for a randomized scoreboard run. Each instance
// sees a behavioural delay-line model of its pipeline.
module tb_pipe_sched;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Instance A signals
  logic [7:0] in_data, pipe_sink, pipe_source, out_data;
  logic       in_valid, in_ready, pipe_reset, out_valid, out_ready;
  logic [3:0] occupancy;

  // Instance B signals
  logic [7:0] b_in_data, b_pipe_sink, b_pipe_source, b_out_data;
  logic       b_in_valid, b_in_ready, b_pipe_reset, b_out_valid, b_out_ready;
  logic [1:0] b_occupancy;

  pipe_sched #(.WIDTH(8), .DELAY(4), .DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .pipe_reset(pipe_reset), .pipe_sink(pipe_sink), .pipe_source(pipe_source),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  pipe_sched #(.WIDTH(8), .DELAY(1), .DEPTH(3)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .pipe_reset(b_pipe_reset), .pipe_sink(b_pipe_sink), .pipe_source(b_pipe_source),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .occupancy(b_occupancy)
  );

  // Delay-line models: 4 stages for A, 1 stage for B.
  logic [7:0] pa [4];
  logic [7:0] pb;
  always @(posedge clk) begin
    pa[0] <= pipe_sink;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
    pb    <= b_pipe_sink;
  end
  assign pipe_source   = pa[3];
  assign b_pipe_source = pb;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshake log for instance A, sampled mid-cycle.
  int         iss_cyc[$];
  int         pop_cyc[$];
  logic [7:0] pop_q[$];
  always @(negedge clk) begin
    if (in_valid && in_ready) iss_cyc.push_back(cyc);
    if (out_valid && out_ready) begin
      pop_q.push_back(out_data);
      pop_cyc.push_back(cyc);
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    iss_cyc.delete();
    pop_cyc.delete();
    pop_q.delete();
  endtask

  // Present one item and hold it until it has been issued (bounded wait).
  task automatic send(input logic [7:0] d);
    int g = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    chk_eq("send_ready", {31'd0, in_ready}, 32'd1);
    tick();
  endtask

  task automatic chk_pops(input string tag, input int n, input logic [7:0] base);
    chk_eq({tag, "_cnt"}, pop_q.size(), n);
    for (int i = 0; i < n && i < pop_q.size(); i++)
      chk_eq({tag, "_data"}, {24'd0, pop_q[i]}, {24'd0, base + 8'(i)});
  endtask

  initial begin
    logic [7:0] b_exp[$];
    int         outstanding;
    logic [7:0] e;

    reset_n = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b0;

    // Test 1: reset state and release sequencing
    repeat (3) tick();
    chk_eq("rst_in_ready",   {31'd0, in_ready},   32'd0);
    chk_eq("rst_pipe_reset", {31'd0, pipe_reset}, 32'd1);
    chk_eq("rst_out_valid",  {31'd0, out_valid},  32'd0);
    chk_eq("rst_occupancy",  {28'd0, occupancy},  32'd0);
    chk_eq("rst_out_data",   {24'd0, out_data},   32'd0);
    clear_log();
    reset_n = 1'b1;
    #1;
    chk_eq("rel_in_ready0",   {31'd0, in_ready},   32'd0);
    chk_eq("rel_pipe_reset0", {31'd0, pipe_reset}, 32'd1);
    tick();
    chk_eq("rel_pipe_reset1", {31'd0, pipe_reset}, 32'd0);
    chk_eq("rel_in_ready1",   {31'd0, in_ready},   32'd1);
    chk_eq("rel_occupancy",   {28'd0, occupancy},  32'd0);
    in_valid = 1'b0;
    chk_eq("rel_no_issue", iss_cyc.size(), 0);

    // Test 2: back-to-back stream with downstream always ready
    clear_log();
    out_ready = 1'b1;
    for (int n = 1; n <= 16; n++) send(8'(n));
    in_valid = 1'b0;
    repeat (10) tick();
    chk_pops("stream", 16, 8'h01);
    if (iss_cyc.size() > 0 && pop_cyc.size() > 0)
      chk_eq("stream_latency", pop_cyc[0] - iss_cyc[0], 5);
    else
      chk_eq("stream_latency_log", pop_cyc.size(), 16);
    if (pop_cyc.size() == 16)
      chk_eq("stream_rate", pop_cyc[15] - pop_cyc[0], 15);
    chk_eq("stream_occ", {28'd0, occupancy}, 32'd0);

    // Test 3: downstream stalled, credits stop upstream at DEPTH
    clear_log();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(8'h21 + 8'(k));
    in_data = 8'hEE;
    repeat (10) tick();
    chk_eq("stall_issues",   iss_cyc.size(), 8);
    chk_eq("stall_in_ready", {31'd0, in_ready},  32'd0);
    chk_eq("stall_occ",      {28'd0, occupancy}, 32'd8);
    chk_eq("stall_out_data", {24'd0, out_data},  32'h21);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();
    chk_pops("stall_drain", 8, 8'h21);
    chk_eq("stall_drain_occ",   {28'd0, occupancy}, 32'd0);
    chk_eq("stall_drain_valid", {31'd0, out_valid}, 32'd0);

    // Test 4: full FIFO, then concurrent issue and pop
    clear_log();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(8'h31 + 8'(k));
    in_valid = 1'b0;
    repeat (6) tick();
    chk_eq("full_occ",      {28'd0, occupancy}, 32'd8);
    chk_eq("full_in_ready", {31'd0, in_ready},  32'd0);
    chk_eq("full_out_data", {24'd0, out_data},  32'h31);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h41;
    tick();
    chk_eq("full_pop_occ", {28'd0, occupancy}, 32'd7);
    for (int k = 0; k < 8; k++) begin
      in_data = 8'h41 + 8'(k);
      tick();
      chk_eq("both_occ", {28'd0, occupancy}, 32'd7);
    end
    in_valid = 1'b0;
    repeat (12) tick();
    chk_eq("both_issues", iss_cyc.size(), 16);
    chk_eq("both_cnt", pop_q.size(), 16);
    for (int i = 0; i < 16 && i < pop_q.size(); i++)
      chk_eq("both_data", {24'd0, pop_q[i]},
             (i < 8) ? 32'h31 + 32'(i) : 32'h41 + 32'(i - 8));
    chk_eq("both_drain_occ", {28'd0, occupancy}, 32'd0);

    // Test 5: reset with three in flight and two buffered
    clear_log();
    out_ready = 1'b0;
    send(8'h51);
    send(8'h52);
    in_valid = 1'b0;
    repeat (5) tick();
    send(8'h53);
    send(8'h54);
    send(8'h55);
    in_valid = 1'b0;
    chk_eq("mid_occ",   {28'd0, occupancy}, 32'd5);
    chk_eq("mid_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_eq("mid_rst_valid",    {31'd0, out_valid}, 32'd0);
    chk_eq("mid_rst_occ",      {28'd0, occupancy}, 32'd0);
    chk_eq("mid_rst_data",     {24'd0, out_data},  32'd0);
    chk_eq("mid_rst_in_ready", {31'd0, in_ready},  32'd0);
    tick();
    reset_n = 1'b1;
    clear_log();
    out_ready = 1'b1;
    repeat (10) tick();
    chk_eq("post_rst_pops",  pop_q.size(), 0);
    chk_eq("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("post_rst_occ",   {28'd0, occupancy}, 32'd0);
    send(8'h61);
    in_valid = 1'b0;
    repeat (8) tick();
    chk_pops("post_rst_new", 1, 8'h61);
    chk_eq("post_rst_new_occ", {28'd0, occupancy}, 32'd0);

    // Test 6: DELAY=1, DEPTH=3, random handshakes against a scoreboard
    outstanding = 0;
    for (int c = 0; c < 10010; c++) begin
      if (c < 10000) begin
        b_in_valid  = 1'($urandom_range(0, 1));
        b_in_data   = 8'($urandom);
        b_out_ready = 1'($urandom_range(0, 1));
      end else begin
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
      end
      chk_eq("b_occ_inv", {30'd0, b_occupancy}, 32'(outstanding));
      chk_eq("b_in_ready", {31'd0, b_in_ready}, {31'd0, outstanding != 3});
      if (b_out_valid && b_out_ready) begin
        if (b_exp.size() > 0) begin
          e = b_exp.pop_front();
          chk_eq("b_data", {24'd0, b_out_data}, {24'd0, e});
        end else begin
          chk_eq("b_unexpected_pop", {31'd0, b_out_valid}, 32'd0);
        end
        outstanding--;
      end
      if (b_in_valid && b_in_ready) begin
        b_exp.push_back(b_in_data);
        outstanding++;
      end
      tick();
    end
    chk_eq("b_drain_occ",   {30'd0, b_occupancy}, 32'd0);
    chk_eq("b_drain_valid", {31'd0, b_out_valid}, 32'd0);
    chk_eq("b_drain_left",  b_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
